// File: rtl/dwt_level_sequencer.sv
// dwt_level_sequencer
// Runs a multi-level 2-D DWT by framing sample-pair streams into a Dwt97 core.
// Level 0 pulls from the s_* stream; deeper levels pull LL feedback from fb_*.
// After each level's last input beat, the block waits for the core to emit
// width*height/2 output beats before it moves to the next level or completes.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_start_i             start pulse (IDLE only)
//   cfg_width_i/height_i    level-0 image size in samples
//   cfg_levels_i            number of decomposition levels
//   busy_o, done_o, err_o   status: active, completion pulse, reject pulse
//   level_o                 current level index
//   s_*                     level-0 pair stream {odd, even}
//   fb_*                    LL feedback pair stream (levels >= 1)
//   core_*                  framed stream to the core (sof/eol)
//   out_valid_i/ready_i     core output handshake, observed only
module dwt_level_sequencer #(
  parameter int unsigned DataWidth       = 16,
  parameter int unsigned MaximumSideSize = 512,
  parameter int unsigned MaxLevels       = 5
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                cfg_start_i,
  input  logic [$clog2(MaximumSideSize):0]    cfg_width_i,
  input  logic [$clog2(MaximumSideSize):0]    cfg_height_i,
  input  logic [$clog2(MaxLevels+1)-1:0]      cfg_levels_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o,
  output logic [$clog2(MaxLevels)-1:0]        level_o,
  output logic                                s_ready_o,
  input  logic                                s_valid_i,
  input  logic [2*DataWidth-1:0]              s_data_i,
  output logic                                fb_ready_o,
  input  logic                                fb_valid_i,
  input  logic [2*DataWidth-1:0]              fb_data_i,
  input  logic                                core_ready_i,
  output logic                                core_valid_o,
  output logic                                core_sof_o,
  output logic                                core_eol_o,
  output logic [2*DataWidth-1:0]              core_data_o,
  input  logic                                out_valid_i,
  input  logic                                out_ready_i
);

  localparam int unsigned SzW   = $clog2(MaximumSideSize) + 1;
  localparam int unsigned LvW   = $clog2(MaxLevels + 1);
  localparam int unsigned LevOW = $clog2(MaxLevels);
  localparam int unsigned OutW  = $clog2(MaximumSideSize * MaximumSideSize / 2 + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [SzW-1:0]    width_q, width_d;
  logic [SzW-1:0]    height_q, height_d;
  logic [LvW-1:0]    levels_q, levels_d;
  logic [LevOW-1:0]  level_q, level_d;
  logic [SzW-1:0]    col_q, col_d;
  logic [SzW-1:0]    row_q, row_d;
  logic [OutW-1:0]   out_cnt_q, out_cnt_d;
  logic              err_q, err_d;

  logic              cfg_bad_c;
  logic [SzW-1:0]    lvl_mask_c;
  logic [LvW-1:0]    shift_amt_c;
  logic              feed_c;
  logic              sel_fb_c;
  logic              sel_valid_c;
  logic [SzW-1:0]    half_w_c;
  logic              last_col_c;
  logic              last_row_c;
  logic              xfer_c;
  logic              out_beat_c;
  logic [OutW-1:0]   out_target_c;

  // Configuration screening; a shift by levels-1 wraps harmlessly when levels is 0
  always_comb begin
    cfg_bad_c   = 1'b0;
    lvl_mask_c  = SzW'((32'd1 << cfg_levels_i) - 32'd1);
    shift_amt_c = cfg_levels_i - LvW'(1);
    if (cfg_levels_i == '0 || 32'(cfg_levels_i) > MaxLevels) cfg_bad_c = 1'b1;
    if (32'(cfg_width_i) > MaximumSideSize || 32'(cfg_height_i) > MaximumSideSize) cfg_bad_c = 1'b1;
    if ((cfg_width_i & lvl_mask_c) != '0 || (cfg_height_i & lvl_mask_c) != '0) cfg_bad_c = 1'b1;
    if ((cfg_width_i >> shift_amt_c) < SzW'(4) || (cfg_height_i >> shift_amt_c) < SzW'(4)) cfg_bad_c = 1'b1;
  end

  // Source mux and framing; framing depends only on counters, so it holds under stall
  assign feed_c       = (state_q == FEED);
  assign sel_fb_c     = (level_q != '0);
  assign sel_valid_c  = sel_fb_c ? fb_valid_i : s_valid_i;
  assign half_w_c     = width_q >> 1;
  assign last_col_c   = (col_q == half_w_c - SzW'(1));
  assign last_row_c   = (row_q == height_q - SzW'(1));

  assign core_valid_o = feed_c & sel_valid_c;
  assign s_ready_o    = feed_c & ~sel_fb_c & core_ready_i;
  assign fb_ready_o   = feed_c & sel_fb_c & core_ready_i;
  assign core_data_o  = sel_fb_c ? fb_data_i : s_data_i;
  assign core_sof_o   = feed_c & (col_q == '0) & (row_q == '0);
  assign core_eol_o   = feed_c & last_col_c;
  assign xfer_c       = core_valid_o & core_ready_i;

  // Output beats past the level's total are ignored
  assign out_target_c = OutW'((32'(width_q) * 32'(height_q)) >> 1);
  assign out_beat_c   = (state_q == FEED || state_q == DRAIN) && out_valid_i && out_ready_i
                        && (out_cnt_q != out_target_c);

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign err_o   = err_q;
  assign level_o = level_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      width_q   <= '0;
      height_q  <= '0;
      levels_q  <= '0;
      level_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      levels_q  <= levels_d;
      level_q   <= level_d;
      col_q     <= col_d;
      row_q     <= row_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    levels_d  = levels_q;
    level_d   = level_q;
    col_d     = col_q;
    row_d     = row_q;
    out_cnt_d = out_cnt_q;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_start_i) begin
          if (cfg_bad_c) begin
            err_d = 1'b1;
          end else begin
            width_d   = cfg_width_i;
            height_d  = cfg_height_i;
            levels_d  = cfg_levels_i;
            level_d   = '0;
            col_d     = '0;
            row_d     = '0;
            out_cnt_d = '0;
            state_d   = FEED;
          end
        end
      end
      FEED: begin
        if (out_beat_c) out_cnt_d = out_cnt_q + OutW'(1);
        if (xfer_c) begin
          if (last_col_c) begin
            col_d = '0;
            if (last_row_c) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + SzW'(1);
            end
          end else begin
            col_d = col_q + SzW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_beat_c) out_cnt_d = out_cnt_q + OutW'(1);
        if (out_cnt_q == out_target_c) begin
          state_d = (32'(level_q) + 32'd1 == 32'(levels_q)) ? DONE : NEXT;
        end
      end
      NEXT: begin
        width_d   = width_q >> 1;
        height_d  = height_q >> 1;
        level_d   = level_q + LevOW'(1);
        col_d     = '0;
        row_d     = '0;
        out_cnt_d = '0;
        state_d   = FEED;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
